// File: rtl/hazard_detect_pkg.sv
// ============================================================================
// Module   : hazard_detect_pkg
// Brief    : Opcode, forward-code and FSM encodings shared by the hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_detect_pkg;

    localparam int XREG_BITS = 5;
    localparam int OP_BITS   = 7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    localparam logic [2:0] FWD_NONE    = 3'd0;
    localparam logic [2:0] FWD_EX_RS1  = 3'd1;
    localparam logic [2:0] FWD_EX_RS2  = 3'd2;
    localparam logic [2:0] FWD_MEM_RS1 = 3'd3;
    localparam logic [2:0] FWD_MEM_RS2 = 3'd4;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_STALL   = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;

    typedef struct packed {
        logic m_rs1;
        logic m_rs2;
    } match_t;

    function automatic logic writes_rd(input logic [OP_BITS-1:0] op);
        return (op != OP_STORE) && (op != OP_BRANCH);
    endfunction

    function automatic logic reads_rs1(input logic [OP_BITS-1:0] op);
        return (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
    endfunction

    function automatic logic reads_rs2(input logic [OP_BITS-1:0] op);
        return (op == OP_RTYPE) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect_if.sv
// ============================================================================
// Module   : hazard_detect_if
// Brief    : Decode-side inputs and forward/stall outputs of the hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_detect_if #(
    parameter int XREG_W = 5,
    parameter int OP_W   = 7
);
    logic              id_valid;
    logic [OP_W-1:0]   id_op;
    logic [XREG_W-1:0] id_rs1;
    logic [XREG_W-1:0] id_rs2;
    logic [XREG_W-1:0] id_rd;
    logic              branch_taken;
    logic              mem_ready;
    logic              is_hazard1;
    logic [2:0]        hazard_reg1;
    logic              is_hazard2;
    logic [2:0]        hazard_reg2;
    logic [OP_W-1:0]   fwd_op;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;

    modport master (
        output id_valid, id_op, id_rs1, id_rs2, id_rd, branch_taken, mem_ready,
        input  is_hazard1, hazard_reg1, is_hazard2, hazard_reg2, fwd_op,
               stall_if, stall_id, bubble_ex
    );

    modport slave (
        input  id_valid, id_op, id_rs1, id_rs2, id_rd, branch_taken, mem_ready,
        output is_hazard1, hazard_reg1, is_hazard2, hazard_reg2, fwd_op,
               stall_if, stall_id, bubble_ex
    );
endinterface

`default_nettype wire

// File: rtl/hazard_match.sv
// ============================================================================
// Module   : hazard_match
// Brief    : Compares one in-flight producer slot against the decode operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_match
    import hazard_detect_pkg::*;
#(
    parameter int XREG_W = XREG_BITS,
    parameter int OP_W   = OP_BITS
) (
    input  wire logic              i_slot_valid,
    input  wire logic [XREG_W-1:0] i_slot_rd,
    input  wire logic [OP_W-1:0]   i_slot_op,
    input  wire logic [OP_W-1:0]   i_cons_op,
    input  wire logic [XREG_W-1:0] i_cons_rs1,
    input  wire logic [XREG_W-1:0] i_cons_rs2,
    output match_t                 o_match
);
    logic w_live;

    // x0 is hard-wired zero, so a producer targeting it never forwards.
    always_comb begin
        w_live        = i_slot_valid && writes_rd(i_slot_op) && (i_slot_rd != '0);
        o_match.m_rs1 = w_live && reads_rs1(i_cons_op) && (i_cons_rs1 == i_slot_rd);
        o_match.m_rs2 = w_live && reads_rs2(i_cons_op) && (i_cons_rs2 == i_slot_rd);
    end

endmodule

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module   : hazard_detect
// Brief    : RAW hazard tracking, forward-code generation and stall control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import hazard_detect_pkg::*;
#(
    parameter int XREG_W = XREG_BITS,
    parameter int OP_W   = OP_BITS
) (
    input  wire logic      clk,
    input  wire logic      rst,
    hazard_detect_if.slave bus
);
    logic [1:0]        state_q, state_d, saved_q, saved_d, cnt_q, cnt_d;
    logic              d1_valid_q, d1_valid_d, d2_valid_q, d2_valid_d;
    logic [XREG_W-1:0] d1_rd_q, d1_rd_d, d2_rd_q, d2_rd_d;
    logic [OP_W-1:0]   d1_op_q, d1_op_d, d2_op_q, d2_op_d;
    logic              is_hazard1_q, is_hazard1_d, is_hazard2_q, is_hazard2_d;
    logic [2:0]        hazard_reg1_q, hazard_reg1_d, hazard_reg2_q, hazard_reg2_d;
    logic [OP_W-1:0]   fwd_op_q, fwd_op_d;

    logic [1:0]        w_slot_valid;
    logic [XREG_W-1:0] w_slot_rd [2];
    logic [OP_W-1:0]   w_slot_op [2];
    match_t            w_match   [2];
    logic              w_e1_rs1, w_e1_rs2, w_e2_rs1, w_e2_rs2;
    logic              w_load_use, w_dual1, w_dual2, w_need_stall, w_eval;
    logic [1:0]        w_stall_cnt, w_eff_state;
    logic              w_stall, w_bubble;

    assign w_slot_valid = {d2_valid_q, d1_valid_q};
    assign w_slot_rd[0] = d1_rd_q;
    assign w_slot_rd[1] = d2_rd_q;
    assign w_slot_op[0] = d1_op_q;
    assign w_slot_op[1] = d2_op_q;

    for (genvar i = 0; i < 2; i++) begin : g_match
        hazard_match #(.XREG_W(XREG_W), .OP_W(OP_W)) u_match (
            .i_slot_valid (w_slot_valid[i]),
            .i_slot_rd    (w_slot_rd[i]),
            .i_slot_op    (w_slot_op[i]),
            .i_cons_op    (bus.id_op),
            .i_cons_rs1   (bus.id_rs1),
            .i_cons_rs2   (bus.id_rs2),
            .o_match      (w_match[i])
        );
    end

    // The nearer producer owns an operand; the farther slot only sees what is left.
    assign w_e1_rs1     = w_match[0].m_rs1 && bus.id_valid;
    assign w_e1_rs2     = w_match[0].m_rs2 && bus.id_valid;
    assign w_e2_rs1     = w_match[1].m_rs1 && bus.id_valid && !w_e1_rs1;
    assign w_e2_rs2     = w_match[1].m_rs2 && bus.id_valid && !w_e1_rs2;
    assign w_load_use   = (d1_op_q == OP_LOAD) && (w_e1_rs1 || w_e1_rs2);
    assign w_dual1      = w_e1_rs1 && w_e1_rs2;
    assign w_dual2      = w_e2_rs1 && w_e2_rs2;
    assign w_need_stall = w_load_use || w_dual1 || w_dual2;
    assign w_stall_cnt  = w_dual1 ? 2'd3 : (w_dual2 ? 2'd2 : 2'd1);
    assign w_eff_state  = (state_q == ST_MEMWAIT) ? saved_q : state_q;
    assign w_eval       = (w_eff_state != ST_STALL) || (cnt_q == 2'd1);

    always_comb begin
        state_d       = state_q;
        saved_d       = saved_q;
        cnt_d         = cnt_q;
        d1_valid_d    = d1_valid_q;
        d1_rd_d       = d1_rd_q;
        d1_op_d       = d1_op_q;
        d2_valid_d    = d2_valid_q;
        d2_rd_d       = d2_rd_q;
        d2_op_d       = d2_op_q;
        is_hazard1_d  = is_hazard1_q;
        hazard_reg1_d = hazard_reg1_q;
        is_hazard2_d  = is_hazard2_q;
        hazard_reg2_d = hazard_reg2_q;
        fwd_op_d      = fwd_op_q;
        w_stall       = 1'b0;
        w_bubble      = 1'b0;
        if (!bus.mem_ready) begin
            state_d = ST_MEMWAIT;
            saved_d = w_eff_state;
            w_stall = 1'b1;
        end else begin
            d2_valid_d    = d1_valid_q;
            d2_rd_d       = d1_rd_q;
            d2_op_d       = d1_op_q;
            d1_valid_d    = 1'b0;
            d1_rd_d       = bus.id_rd;
            d1_op_d       = bus.id_op;
            is_hazard1_d  = 1'b0;
            hazard_reg1_d = FWD_NONE;
            is_hazard2_d  = 1'b0;
            hazard_reg2_d = FWD_NONE;
            fwd_op_d      = '0;
            if (bus.branch_taken) begin
                state_d  = ST_RUN;
                cnt_d    = 2'd0;
                w_bubble = 1'b1;
            end else if (w_eval && !w_need_stall) begin
                state_d       = ST_RUN;
                cnt_d         = 2'd0;
                d1_valid_d    = bus.id_valid;
                is_hazard1_d  = w_e1_rs1 || w_e1_rs2;
                hazard_reg1_d = w_e1_rs1 ? FWD_EX_RS1 : (w_e1_rs2 ? FWD_EX_RS2 : FWD_NONE);
                is_hazard2_d  = w_e2_rs1 || w_e2_rs2;
                hazard_reg2_d = w_e2_rs1 ? FWD_MEM_RS1 : (w_e2_rs2 ? FWD_MEM_RS2 : FWD_NONE);
                fwd_op_d      = (w_e2_rs1 || w_e2_rs2) ? d2_op_q : '0;
            end else begin
                state_d  = ST_STALL;
                cnt_d    = w_eval ? w_stall_cnt : (cnt_q - 2'd1);
                w_stall  = 1'b1;
                w_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            saved_q       <= ST_RUN;
            cnt_q         <= 2'd0;
            d1_valid_q    <= 1'b0;
            d1_rd_q       <= '0;
            d1_op_q       <= '0;
            d2_valid_q    <= 1'b0;
            d2_rd_q       <= '0;
            d2_op_q       <= '0;
            is_hazard1_q  <= 1'b0;
            hazard_reg1_q <= FWD_NONE;
            is_hazard2_q  <= 1'b0;
            hazard_reg2_q <= FWD_NONE;
            fwd_op_q      <= '0;
        end else begin
            state_q       <= state_d;
            saved_q       <= saved_d;
            cnt_q         <= cnt_d;
            d1_valid_q    <= d1_valid_d;
            d1_rd_q       <= d1_rd_d;
            d1_op_q       <= d1_op_d;
            d2_valid_q    <= d2_valid_d;
            d2_rd_q       <= d2_rd_d;
            d2_op_q       <= d2_op_d;
            is_hazard1_q  <= is_hazard1_d;
            hazard_reg1_q <= hazard_reg1_d;
            is_hazard2_q  <= is_hazard2_d;
            hazard_reg2_q <= hazard_reg2_d;
            fwd_op_q      <= fwd_op_d;
        end
    end

    assign bus.is_hazard1  = is_hazard1_q;
    assign bus.hazard_reg1 = hazard_reg1_q;
    assign bus.is_hazard2  = is_hazard2_q;
    assign bus.hazard_reg2 = hazard_reg2_q;
    assign bus.fwd_op      = fwd_op_q;
    assign bus.stall_if    = w_stall && !rst;
    assign bus.stall_id    = w_stall && !rst;
    assign bus.bubble_ex   = w_bubble && !rst;

endmodule

`default_nettype wire

// File: tb/tb_hazard_detect.sv
// ============================================================================
// Module   : tb_hazard_detect
// Brief    : Directed cycle-by-cycle vectors for the hazard detection unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_detect;

    localparam logic [6:0] LD = 7'h03;
    localparam logic [6:0] ST = 7'h23;
    localparam logic [6:0] RT = 7'h33;
    localparam logic [6:0] IT = 7'h13;
    localparam logic [6:0] LU = 7'h37;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_detect_if #(.XREG_W(5), .OP_W(7)) bus ();

    hazard_detect #(.XREG_W(5), .OP_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One record per cycle: inputs for the cycle, then the outputs seen in it
    // (forward codes from the previous edge, stall/bubble from this cycle).
    typedef struct packed {
        logic       v;
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       br;
        logic       mr;
        logic       h1;
        logic [2:0] r1;
        logic       h2;
        logic [2:0] r2;
        logic [6:0] fop;
        logic       st;
        logic       bub;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic v, input logic [6:0] op,
                                input logic [4:0] rs1, rs2, rd,
                                input logic br, mr, h1, input logic [2:0] r1,
                                input logic h2, input logic [2:0] r2,
                                input logic [6:0] fop, input logic st, bub);
        vec_t t;
        t = '{v, op, rs1, rs2, rd, br, mr, h1, r1, h2, r2, fop, st, bub};
        return t;
    endfunction

    function automatic vec_t idle();
        return mk(0, 7'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0);
    endfunction

    task automatic compare(input logic [17:0] exp, input string nm);
        logic [17:0] act;
        act = {bus.is_hazard1, bus.hazard_reg1, bus.is_hazard2, bus.hazard_reg2,
               bus.fwd_op, bus.stall_if, bus.stall_id, bus.bubble_ex};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%05h want=%05h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input vec_t t, input bit chk, input string nm);
        @(posedge clk);
        #1;
        rst              = r;
        bus.id_valid     = t.v;
        bus.id_op        = t.op;
        bus.id_rs1       = t.rs1;
        bus.id_rs2       = t.rs2;
        bus.id_rd        = t.rd;
        bus.branch_taken = t.br;
        bus.mem_ready    = t.mr;
        @(negedge clk);
        if (chk)
            compare({t.h1, t.r1, t.h2, t.r2, t.fop, t.st, t.st, t.bub}, nm);
    endtask

    initial begin
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_op = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_rd = '0; bus.branch_taken = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare(18'h0, "reset");

        // add x3,x1,x2 ; add x4,x3,x5
        tbl.push_back(mk(1, RT, 1, 2, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, RT, 3, 5, 4, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(0, 7'h00, 0, 0, 0, 0, 1, 1, 1, 0, 0, 7'h00, 0, 0));
        tbl.push_back(idle());
        // lw x3 ; nop ; sub x4,x5,x3
        tbl.push_back(mk(1, LD, 1, 0, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, IT, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, RT, 5, 3, 4, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(0, 7'h00, 0, 0, 0, 0, 1, 0, 0, 1, 4, LD, 0, 0));
        tbl.push_back(idle());
        // lw x3 ; add x4,x3,x2 : one load-use stall
        tbl.push_back(mk(1, LD, 1, 0, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, RT, 3, 2, 4, 0, 1, 0, 0, 0, 0, 7'h00, 1, 1));
        tbl.push_back(mk(1, RT, 3, 2, 4, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(0, 7'h00, 0, 0, 0, 0, 1, 0, 0, 1, 3, LD, 0, 0));
        tbl.push_back(idle());
        // addi x2,x0,5 ; add x6,x2,x2 : three stalls
        tbl.push_back(mk(1, IT, 0, 5, 2, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, RT, 2, 2, 6, 0, 1, 0, 0, 0, 0, 7'h00, 1, 1));
        tbl.push_back(mk(1, RT, 2, 2, 6, 0, 1, 0, 0, 0, 0, 7'h00, 1, 1));
        tbl.push_back(mk(1, RT, 2, 2, 6, 0, 1, 0, 0, 0, 0, 7'h00, 1, 1));
        tbl.push_back(mk(1, RT, 2, 2, 6, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(idle());
        // add x0,x1,x2 ; add x4,x0,x0
        tbl.push_back(mk(1, RT, 1, 2, 0, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, RT, 0, 0, 4, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(idle());
        // x5 produced twice ; add x8,x5,x9 -> nearer producer wins
        tbl.push_back(mk(1, RT, 1, 2, 5, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, RT, 6, 7, 5, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, RT, 5, 9, 8, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(0, 7'h00, 0, 0, 0, 0, 1, 1, 1, 0, 0, 7'h00, 0, 0));
        tbl.push_back(idle());
        // add x5 ; add x6 ; add x7,x6,x5 -> codes 1 and 4
        tbl.push_back(mk(1, RT, 1, 2, 5, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, RT, 1, 2, 6, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, RT, 6, 5, 7, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(0, 7'h00, 0, 0, 0, 0, 1, 1, 1, 1, 4, RT, 0, 0));
        tbl.push_back(idle());
        // add x5 ; bubble ; add x9,x5,x5 -> two stalls
        tbl.push_back(mk(1, RT, 1, 2, 5, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(mk(1, RT, 5, 5, 9, 0, 1, 0, 0, 0, 0, 7'h00, 1, 1));
        tbl.push_back(mk(1, RT, 5, 5, 9, 0, 1, 0, 0, 0, 0, 7'h00, 1, 1));
        tbl.push_back(mk(1, RT, 5, 5, 9, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(idle());
        // add x3 ; sw x3,0(x4) ; add x10,x3,x0 -> store reads rs2, never writes
        tbl.push_back(mk(1, RT, 1, 2, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, ST, 4, 3, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, RT, 3, 0, 10, 0, 1, 1, 2, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(0, 7'h00, 0, 0, 0, 0, 1, 0, 0, 1, 3, RT, 0, 0));
        tbl.push_back(idle());
        // add x3 ; lui x7 with x3 in the rs fields -> no hazard
        tbl.push_back(mk(1, RT, 1, 2, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(1, LU, 3, 3, 7, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(idle());
        // add x3 ; invalid slot carrying x3,x3 -> no stall
        tbl.push_back(mk(1, RT, 1, 2, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(mk(0, RT, 3, 3, 4, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(idle());

        foreach (tbl[i]) cyc(0, tbl[i], 1, $sformatf("tbl[%0d]", i));

        // lw x3 ; add x4,x3,x3 with four memory-wait cycles inside the stall
        cyc(0, mk(1, LD, 1, 0, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 1, "mw_ld");
        cyc(0, mk(1, RT, 3, 3, 4, 0, 1, 0, 0, 0, 0, 7'h00, 1, 1), 1, "mw_stall0");
        for (int k = 0; k < 4; k++)
            cyc(0, mk(1, RT, 3, 3, 4, 0, 0, 0, 0, 0, 0, 7'h00, 1, 0), 1, $sformatf("mw_wait%0d", k));
        cyc(0, mk(1, RT, 3, 3, 4, 0, 1, 0, 0, 0, 0, 7'h00, 1, 1), 1, "mw_stall1");
        cyc(0, mk(1, RT, 3, 3, 4, 0, 1, 0, 0, 0, 0, 7'h00, 1, 1), 1, "mw_stall2");
        cyc(0, mk(1, RT, 3, 3, 4, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 1, "mw_issue");
        cyc(0, idle(), 1, "mw_after");
        cyc(0, idle(), 0, "");

        // memory wait holds registered forward codes
        cyc(0, mk(1, RT, 1, 2, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 0, "");
        cyc(0, mk(1, RT, 3, 5, 4, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 0, "");
        cyc(0, mk(0, 7'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7'h00, 1, 0), 1, "mw_hold0");
        cyc(0, mk(0, 7'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7'h00, 1, 0), 1, "mw_hold1");
        cyc(0, mk(0, 7'h00, 0, 0, 0, 0, 1, 1, 1, 0, 0, 7'h00, 0, 0), 1, "mw_release");
        cyc(0, idle(), 1, "mw_clear");
        cyc(0, idle(), 0, "");

        // branch flush during a stall
        cyc(0, mk(1, LD, 1, 0, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 0, "");
        cyc(0, mk(1, RT, 3, 3, 4, 0, 1, 0, 0, 0, 0, 7'h00, 1, 1), 1, "fl_stall");
        cyc(0, mk(1, RT, 3, 3, 4, 1, 1, 0, 0, 0, 0, 7'h00, 0, 1), 1, "fl_flush");
        cyc(0, mk(1, RT, 3, 3, 4, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 1, "fl_run");
        cyc(0, idle(), 0, "");
        cyc(0, idle(), 0, "");

        // flush clears live forward codes
        cyc(0, mk(1, RT, 1, 2, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 0, "");
        cyc(0, mk(1, RT, 3, 5, 4, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 0, "");
        cyc(0, mk(1, RT, 4, 4, 9, 1, 1, 1, 1, 0, 0, 7'h00, 0, 1), 1, "fl_fwd");
        cyc(0, idle(), 1, "fl_fwd_clear");
        cyc(0, idle(), 0, "");

        // flush beats a stall detected in the same cycle
        cyc(0, mk(1, LD, 1, 0, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 0, "");
        cyc(0, mk(1, RT, 3, 3, 4, 1, 1, 0, 0, 0, 0, 7'h00, 0, 1), 1, "fl_beats");
        cyc(0, idle(), 1, "fl_beats_run");
        cyc(0, idle(), 0, "");

        // reset in the middle of a stall
        cyc(0, mk(1, RT, 1, 2, 2, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 0, "");
        cyc(0, mk(1, RT, 2, 2, 6, 0, 1, 0, 0, 0, 0, 7'h00, 1, 1), 1, "rs_stall");
        cyc(1, mk(1, RT, 2, 2, 6, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 0, "");
        cyc(0, mk(1, RT, 2, 2, 6, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 1, "rs_stall_clear");
        cyc(0, idle(), 0, "");
        cyc(0, idle(), 0, "");

        // reset in the middle of a memory wait
        cyc(0, mk(1, RT, 1, 2, 3, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 0, "");
        cyc(0, mk(1, RT, 3, 5, 4, 0, 1, 0, 0, 0, 0, 7'h00, 0, 0), 0, "");
        cyc(0, mk(0, 7'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7'h00, 1, 0), 1, "rs_mw_wait");
        cyc(1, mk(0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'h00, 0, 0), 0, "");
        cyc(0, idle(), 1, "rs_mw_clear");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
